// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this block: PC_MISALIGN_TRAP_EN.
package pc_fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
// One request in flight at a time; response arrives no earlier than the cycle after acceptance.
interface pc_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/pc_fetch_pc_reg.sv
// Program counter register with reset value, load enable and sequential +4 adder.
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [31:0] pc_next_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_add_o
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Take the PC-select mux result only when the fetch sequencer asks for it
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = pc_next_i;
        end
    end

    // PC state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o     = pc_q;
    // Wraps modulo 2^32 by construction
    assign pc_add_o = pc_q + PC_INC;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests,
// one-entry instruction buffer towards decode, and stale-response discard after redirects.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned-PC trap instead of address masking).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_next_i,
    input  logic              redirect_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_add_o,
    pc_fetch_if.master        imem,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i,
    output logic              misalign_o
);

    fetch_state_e state_d, state_q;
    logic [31:0]  inst_d, inst_q;
    logic [31:0]  inst_pc_d, inst_pc_q;
    logic         inst_valid_d, inst_valid_q;
    logic         misalign_d, misalign_q;
    logic         pc_load;
    logic         pc_misaligned;
    logic         req;
    logic         accept;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_en   (pc_load),
        .pc_next_i (pc_next_i),
        .pc_o      (pc_o),
        .pc_add_o  (pc_add_o)
    );

`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned PC blocks issue while the sequencer sits in IDLE/REQ
    assign pc_misaligned = (pc_o[1:0] != 2'b00) &&
                           ((state_q == ST_IDLE) || (state_q == ST_REQ));
    assign imem.addr     = pc_o;
`else
    // Without the trap the low address bits are simply masked; the trap flop never sets
    assign pc_misaligned = 1'b0;
    assign imem.addr     = {pc_o[31:2], 2'b00};
`endif

    assign req      = (state_q == ST_REQ) && !pc_misaligned;
    assign accept   = req && imem.ready;
    assign imem.req = req;

    // Next-state, PC load and instruction-buffer update; redirect overrides every transition
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        pc_load      = 1'b0;

        if (redirect_i) begin
            pc_load      = 1'b1;
            inst_valid_d = 1'b0;
            misalign_d   = 1'b0;
            unique case (state_q)
                ST_IDLE: state_d = ST_REQ;
                // An accepted request still owes a response, which must be thrown away
                ST_REQ:  state_d = accept ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem.rvalid ? ST_REQ : ST_DROP;
                ST_HOLD: state_d = ST_REQ;
                ST_DROP: state_d = imem.rvalid ? ST_REQ : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pc_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (pc_misaligned) begin
                        misalign_d = 1'b1;
                    end else if (accept) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        inst_d       = imem.rdata;
                        inst_pc_d    = pc_o;
                        inst_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (inst_valid_q && id_ready_i) begin
                        pc_load      = 1'b1;
                        inst_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem.rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state, instruction buffer and trap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'h0000_0000;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
    assign misalign_o   = misalign_q;

endmodule
